// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline hazard controller for a five-stage in-order core. It decides each
// cycle whether the front end runs, stalls for a load-use hazard, flushes for
// a taken branch, or freezes entirely while data memory is busy. All state
// updates on the falling clock edge, the same edge as the PC register.
//
// Parameters
//   N_CNT            width of the stall-cycle counter
//
// Inputs
//   clk              pipeline clock (state updates on the falling edge)
//   reset            asynchronous, active-low reset
//   id_valid         ID stage holds a valid instruction
//   id_rs1, id_rs2   ID source register indices
//   id_uses_rs1/rs2  ID instruction actually reads rs1 / rs2
//   id_rd            ID destination register index
//   id_is_load       ID instruction is a load
//   ex_branch_taken  EX resolved a taken branch or jump
//   mem_busy         MEM stage is waiting on data memory
//
// Outputs
//   bubble           PC holds its value
//   ifid_hold        IF/ID register holds
//   idex_hold        ID/EX register holds
//   ifid_flush       load a NOP into IF/ID on the next edge
//   idex_flush       load a NOP into ID/EX on the next edge
//   state            0 = RUN, 1 = MEM_WAIT
//   stall_cycles     saturating count of edges taken with bubble = 1
//   flush_count      saturating count of edges taken in the branch case
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int N_CNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             bubble,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [N_CNT-1:0] stall_cycles,
  output logic [7:0]       flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;

  localparam logic [N_CNT-1:0] STALL_MAX = {N_CNT{1'b1}};
  localparam logic [7:0]       FLUSH_MAX = 8'hFF;

  state_t           state_q, state_d;
  logic             ex_load_q, ex_load_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic [N_CNT-1:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]       flush_count_q, flush_count_d;

  logic freeze_s;
  logic load_use_s;
  logic branch_case_s;
  logic load_use_case_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // Hazard detection: classify the current cycle as freeze, branch or load-use.
  always_comb begin
    freeze_s   = mem_busy | (state_q == ST_MEM_WAIT);
    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    rs1_hit_s  = id_uses_rs1 & (id_rs1 == ex_rd_q);
    rs2_hit_s  = id_uses_rs2 & (id_rs2 == ex_rd_q);
    load_use_s = id_valid & ex_load_q & (ex_rd_q != 5'd0) & (rs1_hit_s | rs2_hit_s);
    // Priority: freeze > branch > load-use. Reset suppresses every case so the
    // counters and outputs stay quiet while reset is held.
    branch_case_s   = reset & ~freeze_s & ex_branch_taken;
    load_use_case_s = reset & ~freeze_s & ~ex_branch_taken & load_use_s;
  end

  // Control outputs: zero-latency decode of the classified cycle.
  always_comb begin
    bubble     = 1'b0;
    ifid_hold  = 1'b0;
    idex_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      // Reset forces every control output low regardless of mem_busy.
      bubble     = 1'b0;
    end else if (freeze_s) begin
      bubble     = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
    end else if (branch_case_s) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_case_s) begin
      // Hold the dependent instruction in ID and send a bubble into EX.
      bubble     = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end else begin
      bubble     = 1'b0;
    end
  end

  // FSM next state: MEM_WAIT is entered and left purely on mem_busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      state_d = mem_busy ? ST_MEM_WAIT : ST_RUN;
      ST_MEM_WAIT: state_d = mem_busy ? ST_MEM_WAIT : ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // EX-stage tracker next state: what instruction will sit in EX after the edge.
  always_comb begin
    ex_load_d = ex_load_q;
    ex_rd_d   = ex_rd_q;
    if (freeze_s) begin
      // ID/EX holds, so EX keeps the same instruction.
      ex_load_d = ex_load_q;
      ex_rd_d   = ex_rd_q;
    end else if (branch_case_s || load_use_case_s) begin
      // A NOP enters EX; clearing ex_load_q limits a load-use stall to one cycle.
      ex_load_d = 1'b0;
      ex_rd_d   = 5'd0;
    end else begin
      ex_load_d = id_valid & id_is_load;
      ex_rd_d   = id_rd;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (bubble && (stall_cycles_q != STALL_MAX)) begin
      stall_cycles_d = stall_cycles_q + {{(N_CNT-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (branch_case_s && (flush_count_q != FLUSH_MAX)) begin
      flush_count_d = flush_count_q + 8'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State registers, updated on the falling edge alongside the PC.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      ex_load_q      <= 1'b0;
      ex_rd_q        <= 5'd0;
      stall_cycles_q <= {N_CNT{1'b0}};
      flush_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      ex_load_q      <= ex_load_d;
      ex_rd_q        <= ex_rd_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic        clk = 1'b1;
  logic        reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken, mem_busy;

  logic        bubble, ifid_hold, idex_hold, ifid_flush, idex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  // Narrow-counter copy so saturation is reachable in a short run.
  logic        s_bubble, s_ifid_hold, s_idex_hold, s_ifid_flush, s_idex_flush;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cycles;
  logic [7:0]  s_flush_count;

  int errors = 0;
  int checks = 0;

  // Reference model: EX contents, whether the previous edge saw mem_busy,
  // and plain integer counters.
  int m_last_busy, m_ex_load, m_ex_rd, m_stall, m_stall_small, m_flush;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .bubble(bubble), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_stall_unit #(.N_CNT(4)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .bubble(s_bubble), .ifid_hold(s_ifid_hold), .idex_hold(s_idex_hold),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .state(s_state),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_last_busy = 0; m_ex_load = 0; m_ex_rd = 0;
    m_stall = 0; m_stall_small = 0; m_flush = 0;
  endtask

  function automatic logic [4:0] ctrl_vec();
    return {bubble, ifid_hold, idex_hold, ifid_flush, idex_flush};
  endfunction

  function automatic logic [4:0] ctrl_vec_small();
    return {s_bubble, s_ifid_hold, s_idex_hold, s_ifid_flush, s_idex_flush};
  endfunction

  // One pipeline cycle: drive mid-cycle, check control outputs, step the
  // falling edge, then check state and counters.
  task automatic cycle(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic bt, input logic mb);
    int freeze, hazard;
    logic [4:0] exp;
    @(posedge clk);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_is_load = ld; ex_branch_taken = bt; mem_busy = mb;
    #1;
    freeze = (mb || m_last_busy != 0) ? 1 : 0;
    hazard = (v && m_ex_load != 0 && m_ex_rd != 0 &&
              ((u1 && int'(rs1) == m_ex_rd) || (u2 && int'(rs2) == m_ex_rd))) ? 1 : 0;
    if (freeze != 0)      exp = 5'b11100;
    else if (bt)          exp = 5'b00011;
    else if (hazard != 0) exp = 5'b11001;
    else                  exp = 5'b00000;
    chk("ctrl", 32'(ctrl_vec()), 32'(exp));
    chk("ctrl_small", 32'(ctrl_vec_small()), 32'(exp));
    // Model update for the coming edge.
    if (exp[4]) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall_small < 15) m_stall_small++;
    end
    if (freeze == 0 && bt && m_flush < 255) m_flush++;
    if (freeze != 0) begin
      // EX unchanged
    end else if (bt || hazard != 0) begin
      m_ex_load = 0;
    end else begin
      m_ex_load = (v && ld) ? 1 : 0;
      m_ex_rd   = int'(rd);
    end
    m_last_busy = mb ? 1 : 0;
    @(negedge clk);
    #1;
    chk("state", 32'(state), 32'(m_last_busy));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("stall_small", 32'(s_stall_cycles), 32'(m_stall_small));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
  endtask

  // Assert reset between edges, check the immediate effect, release mid-cycle.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    @(posedge clk);
    reset = 1'b1;
  endtask

  task automatic nop();
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rd = 5'd0; id_is_load = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b1;
    model_clear();
    #1;
    // Reset state, even with mem_busy asserted.
    chk("reset_ctrl", 32'(ctrl_vec()), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    @(posedge clk);
    mem_busy = 1'b0;
    @(posedge clk);
    reset = 1'b1;

    // Load x5 then add x6,x5,x1: exactly one stall cycle.
    cycle(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_once", 32'(stall_cycles), 32'd1);
    cycle(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_no_restall", 32'(stall_cycles), 32'd1);

    // Load to x0 followed by a use of x0: never a hazard.
    cycle(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("x0_no_stall", 32'(stall_cycles), 32'd1);

    // Branch in the same cycle as a load-use: branch wins, no stall after.
    cycle(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
    chk("br_flush_count", 32'(flush_count), 32'd1);
    cycle(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    chk("br_no_stall", 32'(stall_cycles), 32'd1);

    // mem_busy for 3 cycles with a pending branch: 4 freeze cycles, then flush.
    mid_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("mw_flush_none", 32'(flush_count), 32'd0);
    cycle(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("mw_stall4", 32'(stall_cycles), 32'd4);
    chk("mw_flush1", 32'(flush_count), 32'd1);

    // Long mem_busy saturates the narrow counter at all-ones.
    for (int i = 0; i < 20; i++) cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    nop();
    chk("sat_small", 32'(s_stall_cycles), 32'hF);

    // Reset during MEM_WAIT with mem_busy still high.
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    mid_reset();
    mem_busy = 1'b0;
    nop();

    // Randomized traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0),
            1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
